// File: rtl/ow_master_sequencer.sv
// ow_master_sequencer: bit-level 1-Wire master. Runs one operation at a time
// (reset/presence, write byte, read byte). All slot timing comes from a single
// tick counter that clears on every phase change. One clk cycle = 1 us.
module ow_master_sequencer #(
  parameter int unsigned T_RSTL = 480,  // reset pulse low time
  parameter int unsigned T_RSTH = 480,  // release after reset pulse, incl. presence window
  parameter int unsigned T_PDS  = 70,   // presence sample tick, from reset release
  parameter int unsigned T_SLOT = 60,   // time-slot length
  parameter int unsigned T_REC  = 11,   // recovery between slots
  parameter int unsigned T_LOW1 = 6,    // low time for write-1 and read slots
  parameter int unsigned T_RDS  = 12    // read sample tick from slot start
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [7:0] i_cmd_data,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_presence,
  output logic       o_rsp_err,
  output logic       o_busy,
  output logic       o_bus_oe,
  input  logic       i_bus_in
);

  localparam logic [1:0] OpReset   = 2'b00;
  localparam logic [1:0] OpWrite   = 2'b01;
  localparam logic [1:0] OpRead    = 2'b10;
  localparam logic [1:0] OpIllegal = 2'b11;

  // Terminal tick values for each phase, pre-truncated to the counter width.
  localparam logic [9:0] LpRstlEnd = 10'(T_RSTL - 1);
  localparam logic [9:0] LpRsthEnd = 10'(T_RSTH - 1);
  localparam logic [9:0] LpPds     = 10'(T_PDS);
  localparam logic [9:0] LpSlotEnd = 10'(T_SLOT - 1);
  localparam logic [9:0] LpRecEnd  = 10'(T_REC - 1);
  localparam logic [9:0] LpLow1    = 10'(T_LOW1);
  localparam logic [9:0] LpRds     = 10'(T_RDS);

  typedef enum logic [2:0] {
    StIdle,
    StRstLow,
    StRstHigh,
    StSlot,
    StRec,
    StDone
  } state_e;

  state_e     r_state;
  logic [9:0] r_tick;
  logic [2:0] r_bit_idx;
  logic [1:0] r_op;
  logic [7:0] r_data;
  logic [7:0] r_shift;
  logic       r_presence;
  logic       r_sync1;
  logic       r_sync2;
  logic       r_bus_oe;
  logic       r_cmd_ready;
  logic       r_busy;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_rsp_presence;
  logic       r_rsp_err;

  logic       w_accept;
  logic [9:0] w_tick_next;
  logic       w_full_low;
  logic       w_last_bit;

  assign w_accept    = i_cmd_valid && r_cmd_ready;
  assign w_tick_next = r_tick + 10'd1;
  // A write-0 slot holds the bus low for the whole slot; write-1 and read
  // slots only pull low for T_LOW1 ticks.
  assign w_full_low  = (r_op == OpWrite) && !r_data[r_bit_idx];
  assign w_last_bit  = (r_bit_idx == 3'd7);

  // Two-flop synchronizer on the raw bus level; idles high like the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_bus_in;
      r_sync2 <= r_sync1;
    end
  end

  // Sequencer FSM: phase timing, bit shifting and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_tick         <= '0;
      r_bit_idx      <= '0;
      r_op           <= OpReset;
      r_data         <= '0;
      r_shift        <= '0;
      r_presence     <= 1'b0;
      r_bus_oe       <= 1'b0;
      r_cmd_ready    <= 1'b0;
      r_busy         <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_presence <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_bus_oe <= 1'b0;
          if (!r_cmd_ready) begin
            // First cycle out of reset: open the handshake, accept nothing yet.
            r_cmd_ready <= 1'b1;
          end else if (w_accept) begin
            r_op        <= i_cmd_op;
            r_data      <= i_cmd_data;
            r_tick      <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_presence  <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            unique case (i_cmd_op)
              OpReset: begin
                r_state  <= StRstLow;
                r_bus_oe <= 1'b1;
              end
              OpWrite, OpRead: begin
                r_state  <= StSlot;
                r_bus_oe <= 1'b1;
              end
              OpIllegal: begin
                r_state        <= StDone;
                r_bus_oe       <= 1'b0;
                r_rsp_valid    <= 1'b1;
                r_rsp_data     <= '0;
                r_rsp_presence <= 1'b0;
                r_rsp_err      <= 1'b1;
              end
              default: r_state <= StIdle;
            endcase
          end
        end

        StRstLow: begin
          if (r_tick == LpRstlEnd) begin
            r_state  <= StRstHigh;
            r_tick   <= '0;
            r_bus_oe <= 1'b0;
          end else begin
            r_tick   <= w_tick_next;
            r_bus_oe <= 1'b1;
          end
        end

        StRstHigh: begin
          r_bus_oe <= 1'b0;
          // A responding slave holds the bus low across the sample point.
          if (r_tick == LpPds) begin
            r_presence <= !r_sync2;
          end
          if (r_tick == LpRsthEnd) begin
            r_state        <= StDone;
            r_tick         <= '0;
            r_rsp_valid    <= 1'b1;
            r_rsp_data     <= '0;
            r_rsp_presence <= r_presence;
            r_rsp_err      <= 1'b0;
          end else begin
            r_tick <= w_tick_next;
          end
        end

        StSlot: begin
          if ((r_op == OpRead) && (r_tick == LpRds)) begin
            r_shift[r_bit_idx] <= r_sync2;
          end
          if (r_tick == LpSlotEnd) begin
            r_state  <= StRec;
            r_tick   <= '0;
            r_bus_oe <= 1'b0;
          end else begin
            r_tick   <= w_tick_next;
            r_bus_oe <= w_full_low || (w_tick_next < LpLow1);
          end
        end

        StRec: begin
          if (r_tick == LpRecEnd) begin
            r_tick <= '0;
            if (w_last_bit) begin
              r_state        <= StDone;
              r_bus_oe       <= 1'b0;
              r_rsp_valid    <= 1'b1;
              r_rsp_data     <= (r_op == OpWrite) ? r_data : r_shift;
              r_rsp_presence <= 1'b0;
              r_rsp_err      <= 1'b0;
            end else begin
              r_state   <= StSlot;
              r_bit_idx <= r_bit_idx + 3'd1;
              r_bus_oe  <= 1'b1;
            end
          end else begin
            r_tick   <= w_tick_next;
            r_bus_oe <= 1'b0;
          end
        end

        StDone: begin
          r_state     <= StIdle;
          r_bus_oe    <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state     <= StIdle;
          r_tick      <= '0;
          r_bus_oe    <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_cmd_ready    = r_cmd_ready;
  assign o_busy         = r_busy;
  assign o_bus_oe       = r_bus_oe;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_data     = r_rsp_data;
  assign o_rsp_presence = r_rsp_presence;
  assign o_rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_ow_master_sequencer.sv
// tb_ow_master_sequencer: directed bench for the 1-Wire master sequencer.
// The bus is modelled as a wired-AND of the master drive and a slave pull.
module tb_ow_master_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_cmd_valid;
  logic [1:0] i_cmd_op;
  logic [7:0] i_cmd_data;
  logic       o_cmd_ready;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_data;
  logic       o_rsp_presence;
  logic       o_rsp_err;
  logic       o_busy;
  logic       o_bus_oe;
  logic       slave_pull;
  logic       w_bus_in;

  assign w_bus_in = !(o_bus_oe || slave_pull);

  ow_master_sequencer u_dut (
    .clk            (clk),
    .rst            (rst),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_op       (i_cmd_op),
    .i_cmd_data     (i_cmd_data),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_data     (o_rsp_data),
    .o_rsp_presence (o_rsp_presence),
    .o_rsp_err      (o_rsp_err),
    .o_busy         (o_busy),
    .o_bus_oe       (o_bus_oe),
    .i_bus_in       (w_bus_in)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Results gathered by the monitor for the most recent operation.
  int         run_len   [16];
  int         run_start [16];
  int         n_runs;
  int         rv_cycle;
  int         rv_count;
  int         rdy_hi;
  logic [7:0] rv_data;
  logic       rv_pres;
  logic       rv_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Watch the bus cycle by cycle after an accept edge (cycle 1 = first cycle
  // after that edge). mode 1 = presence pulse 20..200 cycles after release,
  // mode 2 = slave holds low through tick 30 of each slot flagged in pull_mask.
  task automatic monitor(input int mode, input logic [7:0] pull_mask,
                         input int max_cycles, input int linger);
    logic prev_oe  = 1'b0;
    int   slot     = 0;
    int   pull_end = -1;
    int   fall_c   = -1;
    int   stop_c   = max_cycles;
    n_runs   = 0;
    rv_cycle = -1;
    rv_count = 0;
    rdy_hi   = 0;
    for (int i = 0; i < 16; i++) begin
      run_len[i]   = 0;
      run_start[i] = 0;
    end
    for (int c = 1; c <= stop_c; c++) begin
      @(negedge clk);
      if (o_bus_oe && !prev_oe) begin
        if (n_runs < 16) begin
          run_start[n_runs] = c;
          n_runs++;
        end
        if (mode == 2 && slot < 8) begin
          if (pull_mask[slot]) begin
            slave_pull = 1'b1;
            pull_end   = c + 30;
          end
          slot++;
        end
      end
      if (o_bus_oe && n_runs > 0) run_len[n_runs-1]++;
      if (!o_bus_oe && prev_oe && fall_c < 0) fall_c = c;
      if (mode == 2 && c > pull_end) slave_pull = 1'b0;
      if (mode == 1) slave_pull = (fall_c > 0) && (c >= fall_c + 20) && (c <= fall_c + 200);
      if (o_rsp_valid) begin
        rv_count++;
        if (rv_cycle < 0) begin
          rv_cycle = c;
          rv_data  = o_rsp_data;
          rv_pres  = o_rsp_presence;
          rv_err   = o_rsp_err;
          stop_c   = c + linger;
        end
      end else if (rv_cycle < 0 && o_cmd_ready) begin
        rdy_hi++;
      end
      prev_oe = o_bus_oe;
    end
    slave_pull = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    @(negedge clk);
    check_eq("ready_before_accept", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_data  = data;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    i_cmd_data  = ~data;
  endtask

  logic [7:0] exp_byte;

  initial begin
    rst         = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_op    = 2'b00;
    i_cmd_data  = 8'h00;
    slave_pull  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_bus_oe", o_bus_oe, 0);
    check_eq("rst_ready", o_cmd_ready, 0);
    check_eq("rst_rsp_valid", o_rsp_valid, 0);
    check_eq("rst_rsp_data", o_rsp_data, 0);
    check_eq("rst_presence", o_rsp_presence, 0);
    check_eq("rst_err", o_rsp_err, 0);
    check_eq("rst_busy", o_busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", o_cmd_ready, 1);
    check_eq("busy_after_rst", o_busy, 0);

    // Reset op with a presence pulse.
    issue(2'b00, 8'h00);
    monitor(1, 8'h00, 1200, 3);
    check_eq("rp_runs", n_runs, 1);
    check_eq("rp_low_start", run_start[0], 1);
    check_eq("rp_low_len", run_len[0], 480);
    check_eq("rp_rv_cycle", rv_cycle, 961);
    check_eq("rp_rv_count", rv_count, 1);
    check_eq("rp_presence", rv_pres, 1);
    check_eq("rp_err", rv_err, 0);
    check_eq("rp_data", rv_data, 0);
    check_eq("rp_ready_busy", rdy_hi, 0);

    // Reset op with the bus left high.
    issue(2'b00, 8'h00);
    monitor(0, 8'h00, 1200, 3);
    check_eq("rn_rv_cycle", rv_cycle, 961);
    check_eq("rn_presence", rv_pres, 0);
    check_eq("rn_rv_count", rv_count, 1);

    // Write 0x55, LSB first.
    exp_byte = 8'h55;
    issue(2'b01, exp_byte);
    monitor(0, 8'h00, 700, 3);
    check_eq("w55_runs", n_runs, 8);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("w55_len%0d", k), run_len[k], exp_byte[k] ? 6 : 60);
      check_eq($sformatf("w55_start%0d", k), run_start[k], 1 + 71 * k);
    end
    check_eq("w55_rv_cycle", rv_cycle, 569);
    check_eq("w55_rv_count", rv_count, 1);
    check_eq("w55_data", rv_data, 8'h55);
    check_eq("w55_data_hold", o_rsp_data, 8'h55);

    // Read byte; slave pulls slots 1,3,4,6 low.
    issue(2'b10, 8'h00);
    monitor(2, 8'h5A, 700, 3);
    check_eq("rd_runs", n_runs, 8);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("rd_len%0d", k), run_len[k], 6);
    end
    check_eq("rd_rv_cycle", rv_cycle, 569);
    check_eq("rd_data", rv_data, 8'hA5);

    // Back-to-back: cmd_valid held across write 0xCC then read.
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'b01;
    i_cmd_data  = 8'hCC;
    @(posedge clk);
    #1;
    i_cmd_op   = 2'b10;
    i_cmd_data = 8'h00;
    monitor(0, 8'h00, 700, 0);
    check_eq("b2b_ready_busy", rdy_hi, 0);
    check_eq("b2b1_rv_cycle", rv_cycle, 569);
    check_eq("b2b1_data", rv_data, 8'hCC);
    @(negedge clk);
    check_eq("b2b_ready_back", o_cmd_ready, 1);
    check_eq("b2b_rv_low", o_rsp_valid, 0);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    monitor(0, 8'h00, 700, 3);
    check_eq("b2b2_first_oe", run_start[0], 1);
    check_eq("b2b2_runs", n_runs, 8);
    check_eq("b2b2_rv_cycle", rv_cycle, 569);
    check_eq("b2b2_data", rv_data, 8'hFF);

    // rst in the middle of a write.
    issue(2'b01, 8'h00);
    monitor(0, 8'h00, 199, 0);
    @(negedge clk);
    check_eq("mid_oe_before", o_bus_oe, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_oe_at_rst", o_bus_oe, 0);
    check_eq("mid_busy_at_rst", o_busy, 0);
    check_eq("mid_rv_at_rst", o_rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    monitor(0, 8'h00, 700, 0);
    check_eq("mid_no_rv", rv_count, 0);
    check_eq("mid_no_oe", n_runs, 0);
    issue(2'b00, 8'h00);
    monitor(1, 8'h00, 1200, 3);
    check_eq("mid_rp_rv_cycle", rv_cycle, 961);
    check_eq("mid_rp_presence", rv_pres, 1);

    // Illegal op.
    issue(2'b11, 8'hAB);
    monitor(0, 8'h00, 20, 3);
    check_eq("ill_rv_cycle", rv_cycle, 1);
    check_eq("ill_rv_count", rv_count, 1);
    check_eq("ill_err", rv_err, 1);
    check_eq("ill_data", rv_data, 0);
    check_eq("ill_presence", rv_pres, 0);
    check_eq("ill_no_oe", n_runs, 0);
    @(negedge clk);
    check_eq("ill_err_hold", o_rsp_err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
